// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED sequencer.
//   state_t      : sequencer FSM states
//   CNT_W        : width of the pulse-count register (holds 16)
//   TICK_W       : width of the tick and heartbeat counters
//   ID_W         : width of requester indices and the round-robin pointer
//   decode_count : maps a 4-bit request count to a pulse count (0 means 16)
package led_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        ON   = 3'd2,
        OFF  = 3'd3,
        GAP  = 3'd4
    } state_t;

    localparam int CNT_W  = 5;
    localparam int TICK_W = 32;
    localparam int ID_W   = 3;

    function automatic logic [CNT_W-1:0] decode_count(input logic [3:0] raw);
        if (raw == 4'd0) begin
            return CNT_W'(16);
        end
        return {1'b0, raw};
    endfunction

endpackage

// File: rtl/led_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector
//   ptr    : index where the search starts (must be < N_REQ)
//   winner : one-hot grant for the first set request at or above ptr, with wrap
//   valid  : high when any request is set
module rr_arbiter
    import led_seq_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    logic [3:0]         pos;

    always_comb begin
        // Rotate so bit 0 of 'rotated' is the requester at ptr.
        doubled = {req, req} >> ptr;
        rotated = doubled[N_REQ-1:0];
        winner  = '0;
        valid   = 1'b0;
        pos     = '0;
        // Walk downward so the lowest rotated offset is the one that sticks.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                pos   = 4'({1'b0, ptr}) + 4'(k);
                valid = 1'b1;
            end
        end
        if (pos >= 4'(N_REQ)) begin
            pos = pos - 4'(N_REQ);
        end
        if (valid) begin
            winner = N_REQ'(1) << pos;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// Shares one debug LED among N_REQ requesters. A granted requester gets a
// burst of 1-16 blink pulses followed by a dark gap; while idle the LED can
// show a heartbeat.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   req       : level request per requester, held until granted
//   req_count : packed 4-bit pulse counts, index i at [4i+3:4i]; 0 means 16
//   hb_en     : heartbeat enable, only looked at while idle
//   grant     : one-hot, one cycle wide, marks the start of a burst
//   active_id : index of the requester owning the current burst
//   busy      : high whenever the sequencer is not idle
//   led       : registered LED drive
//   state_dbg : current FSM state, for observation
//
// Handshake: a requester raises req[i] and keeps it high until it sees
// grant[i]; a request dropped before its grant is simply forgotten.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ON_TICKS  = 1200000,
    parameter int OFF_TICKS = 1200000,
    parameter int GAP_TICKS = 3600000,
    parameter int HB_TICKS  = 6000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [4*N_REQ-1:0]   req_count,
    input  logic                 hb_en,
    output logic [N_REQ-1:0]     grant,
    output logic [ID_W-1:0]      active_id,
    output logic                 busy,
    output logic                 led,
    output logic [2:0]           state_dbg
);

    localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
    localparam logic [TICK_W-1:0] OFF_LAST = TICK_W'(OFF_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_LAST = TICK_W'(GAP_TICKS - 1);
    localparam logic [TICK_W-1:0] HB_LAST  = TICK_W'(HB_TICKS - 1);

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [TICK_W-1:0]  tick;
    logic [TICK_W-1:0]  hb_cnt;
    logic [CNT_W-1:0]   remaining;

    logic [N_REQ-1:0]   win_onehot;
    logic               win_valid;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    next_ptr;
    logic [3:0]         win_raw;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .winner (win_onehot),
        .valid  (win_valid)
    );

    // Index and raw count of the current winner.
    always_comb begin
        win_idx = '0;
        win_raw = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_onehot[k]) begin
                win_idx = ID_W'(k);
                win_raw = req_count[4*k +: 4];
            end
        end
        next_ptr = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            tick      <= '0;
            hb_cnt    <= '0;
            remaining <= '0;
            grant     <= '0;
            active_id <= '0;
            led       <= 1'b0;
        end else begin
            grant <= '0;
            case (state)
                IDLE: begin
                    if (hb_en) begin
                        if (hb_cnt == HB_LAST) begin
                            hb_cnt <= '0;
                            led    <= ~led;
                        end else begin
                            hb_cnt <= hb_cnt + 1'b1;
                        end
                    end else begin
                        hb_cnt <= '0;
                        led    <= 1'b0;
                    end
                    if (|req) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    // A request withdrawn before arbitration leaves the
                    // heartbeat untouched and goes straight back to idle.
                    if (win_valid) begin
                        grant     <= win_onehot;
                        active_id <= win_idx;
                        ptr       <= next_ptr;
                        remaining <= decode_count(win_raw);
                        led       <= 1'b1;
                        tick      <= '0;
                        state     <= ON;
                    end else begin
                        state <= IDLE;
                    end
                end
                ON: begin
                    if (tick == ON_LAST) begin
                        tick  <= '0;
                        led   <= 1'b0;
                        state <= OFF;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                OFF: begin
                    if (tick == OFF_LAST) begin
                        tick      <= '0;
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            state <= GAP;
                        end else begin
                            led   <= 1'b1;
                            state <= ON;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                GAP: begin
                    if (tick == GAP_LAST) begin
                        tick   <= '0;
                        hb_cnt <= '0;
                        led    <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Shares the single board debug LED among N_REQ requesters (UART RX, TX, framing error, user), using round-robin arbitration.
- A granted requester gets a burst of 1-16 blink pulses, followed by a dark gap.
- While no request is pending, the block drives an optional heartbeat blink. At the default 12 MHz clock this toggles every 0.5 s.
- Sits between the UART debug event sources and the top-level LED pin.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ON_TICKS, 1200000, cycles the LED is on per pulse (>=1).
- OFF_TICKS, 1200000, cycles the LED is off after each pulse (>=1).
- GAP_TICKS, 3600000, dark cycles after a burst before returning to idle (>=1).
- HB_TICKS, 6000000, heartbeat half-period in cycles (>=1).

Ports:
- clk  in  1  system clock, 12 MHz nominal.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  level request per requester; held until its grant.
- req_count  in  4*N_REQ  pulse count per requester, packed (index i at bits 4i+3:4i); 0 means 16.
- hb_en  in  1  enables heartbeat blinking while idle.
- grant  out  N_REQ  one-hot, exactly one cycle wide, marks the start of a burst.
- active_id  out  3  index of the requester owning the current burst.
- busy  out  1  high in ARB, ON, OFF and GAP states.
- led  out  1  LED drive, registered.

Behaviour:
- Reset (asynchronous): all outputs are 0, state is IDLE, round-robin pointer is 0, all counters are 0.
- States:
  - IDLE: led follows the heartbeat. If hb_en=0, led=0 and the heartbeat counter is held at 0. If hb_en=1, led toggles when the counter reaches HB_TICKS-1, then the counter wraps to 0.
  - IDLE -> ARB: when |req=1. ARB lasts 1 cycle.
  - ARB: selects the winner and captures its count (0 becomes 16).
    - Winner is the first set req bit starting at the pointer and searching upward with wrap.
    - Pointer is set to winner+1 mod N_REQ.
    - If req is all 0 by ARB (requester withdrew), return to IDLE with no grant.
  - ARB -> ON: on entry, grant[winner]=1 for 1 cycle, led=1, active_id=winner.
  - ON: led=1 for ON_TICKS cycles, then go to OFF.
  - OFF: led=0 for OFF_TICKS cycles, then decrement the remaining count. Go to ON if nonzero, else to GAP.
  - GAP: led=0 for GAP_TICKS cycles, then go to IDLE.
  - Re-entry to IDLE: the heartbeat restarts with led=0 and counter 0.
- Latency: req rising in IDLE at cycle t gives grant and led=1 at t+2.
- Burst length: count*(ON_TICKS+OFF_TICKS) + GAP_TICKS cycles from grant to IDLE.
- Requests are never queued by the block. A req deasserted before its grant is lost.
- A req re-asserted by the owner during its own burst is served after the round-robin turn passes it.
- req_count is sampled only in ARB. Later changes do not affect the running burst.
- hb_en is ignored outside IDLE.
- Tick counters are 32 bits wide, compared against PARAM-1, and never overflow.
- rst asserted mid-burst: led=0, busy=0 and grant=0 immediately. The pointer returns to 0 and no burst resumes after reset release.

Decomposition:
- Package led_seq_pkg holds:
  - state enum {IDLE, ARB, ON, OFF, GAP};
  - CNT_W=5 (holds 16);
  - TICK_W=32;
  - function decoding a count of 0 to 16.
- Sub-module rr_arbiter (N_REQ): combinational; takes req and the pointer, returns a one-hot winner and a valid flag. The pointer register stays in led_sequencer.

Test Plan:
Benches use N_REQ=4, ON=2, OFF=2, GAP=3, HB=5.
- Reset: assert rst mid-run -> led=0, grant=0, busy=0, active_id=0 within the same cycle, with no clock edge needed.
- Heartbeat: hb_en=1, req=0 -> led toggles every 5 cycles (period 10). Drop hb_en -> led=0 on the next edge.
- Single burst: req=4'b0100, req_count[11:8]=3, held until grant.
  - grant=4'b0100 for 1 cycle, 2 cycles after req rises; active_id=2.
  - led pattern is 1100 repeated 3 times, then 000; then IDLE with busy=0.
  - busy=1 for 16 cycles in total (ARB plus 15 burst cycles).
- Round-robin: req=4'b1011 held continuously -> grants in order 0, 1, 3, 0, 1. There are no back-to-back grants to the same index while others are pending.
- Withdrawn request: pulse req[1] for 1 cycle -> enters ARB, finds req=0, returns to IDLE with no grant and led unchanged.
- Count zero and mid-burst reset: req_count=0 -> 16 pulses (64+3 cycles after grant). Assert rst after the 5th pulse -> led=0 immediately, no resumption; the next req[0] is granted first (pointer 0).
